// File: rtl/ingress_dequeue.sv
// Ingress dequeue: four virtual output queues (VOQs) of packet descriptors plus a
// transmit FSM that walks the packet buffer for one granted descriptor at a time.
//
// Ports:
//   clk, reset                        sole clock, synchronous active-high reset
//   enq_valid/enq_voq/enq_len/enq_addr descriptor enqueue request
//   enq_drop                          one-cycle pulse: previous enqueue rejected
//   voq_empty[v]                      VOQ v holds no descriptor
//   sel_en/sel                        scheduler grant and granted VOQ
//   is_busy/busy_voq_num              transmission in progress and its VOQ
//   rd_en/rd_addr/tx_sop/tx_eop       packet-buffer read stream with word markers
//   grant_err                         one-cycle pulse: previous grant was illegal
module ingress_dequeue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enq_valid,
    input  logic [1:0] enq_voq,
    input  logic [5:0] enq_len,
    input  logic [9:0] enq_addr,
    output logic       enq_drop,
    output logic [3:0] voq_empty,
    input  logic       sel_en,
    input  logic [1:0] sel,
    output logic       is_busy,
    output logic [1:0] busy_voq_num,
    output logic       rd_en,
    output logic [9:0] rd_addr,
    output logic       tx_sop,
    output logic       tx_eop,
    output logic       grant_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic {StIdle, StSend} state_e;

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  len_q;
    logic [9:0]  base_q;
    logic [1:0]  voq_q;
    logic        gerr_d;

    logic [15:0]   mem_q [4][DEPTH];
    logic [PW-1:0] wr_ptr_q [4];
    logic [PW-1:0] rd_ptr_q [4];
    logic [CW-1:0] cnt_q [4];

    logic        enq_ok;
    logic        pop;
    logic [3:0]  push_mask;
    logic [3:0]  pop_mask;
    logic [15:0] head;

    always_comb begin
        for (int v = 0; v < 4; v++) begin
            voq_empty[v] = (cnt_q[v] == '0);
        end
    end

    // Fullness is judged on the pre-pop count, so a full VOQ being popped still drops.
    assign enq_ok    = enq_valid && (enq_len != 6'd0) && (cnt_q[enq_voq] < CW'(DEPTH));
    assign pop       = (state_q == StIdle) && sel_en && !voq_empty[sel];
    assign push_mask = enq_ok ? (4'b0001 << enq_voq) : 4'b0000;
    assign pop_mask  = pop ? (4'b0001 << sel) : 4'b0000;
    assign head      = mem_q[sel][rd_ptr_q[sel]];

    // Descriptor storage carries no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        if (!reset && enq_ok) begin
            mem_q[enq_voq][wr_ptr_q[enq_voq]] <= {enq_len, enq_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < 4; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
        end else begin
            for (int v = 0; v < 4; v++) begin
                if (push_mask[v]) wr_ptr_q[v] <= wr_ptr_q[v] + PW'(1);
                if (pop_mask[v])  rd_ptr_q[v] <= rd_ptr_q[v] + PW'(1);
                if (push_mask[v] && !pop_mask[v]) begin
                    cnt_q[v] <= cnt_q[v] + CW'(1);
                end else if (!push_mask[v] && pop_mask[v]) begin
                    cnt_q[v] <= cnt_q[v] - CW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gerr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sel_en) begin
                    if (voq_empty[sel]) begin
                        gerr_d = 1'b1;
                    end else begin
                        state_d = StSend;
                        idx_d   = 6'd0;
                    end
                end
            end
            StSend: begin
                // Re-grant of the busy VOQ is benign; any other grant is an error.
                if (sel_en && (sel != voq_q)) gerr_d = 1'b1;
                if (idx_q == len_q - 6'd1) begin
                    state_d = StIdle;
                    idx_d   = 6'd0;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= 6'd0;
            len_q     <= 6'd0;
            base_q    <= 10'd0;
            voq_q     <= 2'd0;
            enq_drop  <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            enq_drop  <= enq_valid && !enq_ok;
            grant_err <= gerr_d;
            if (pop) begin
                len_q  <= head[15:10];
                base_q <= head[9:0];
                voq_q  <= sel;
            end
        end
    end

    assign is_busy      = (state_q == StSend);
    assign busy_voq_num = is_busy ? voq_q : 2'd0;
    assign rd_en        = is_busy;
    assign rd_addr      = is_busy ? (base_q + {4'd0, idx_q}) : 10'd0;
    assign tx_sop       = is_busy && (idx_q == 6'd0);
    assign tx_eop       = is_busy && (idx_q == len_q - 6'd1);

endmodule

// File: tb/tb_ingress_dequeue.sv
module tb_ingress_dequeue;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       enq_valid;
    logic [1:0] enq_voq;
    logic [5:0] enq_len;
    logic [9:0] enq_addr;
    logic       enq_drop;
    logic [3:0] voq_empty;
    logic       sel_en;
    logic [1:0] sel;
    logic       is_busy;
    logic [1:0] busy_voq_num;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic       tx_sop;
    logic       tx_eop;
    logic       grant_err;

    ingress_dequeue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_voq(enq_voq), .enq_len(enq_len), .enq_addr(enq_addr),
        .enq_drop(enq_drop), .voq_empty(voq_empty),
        .sel_en(sel_en), .sel(sel),
        .is_busy(is_busy), .busy_voq_num(busy_voq_num),
        .rd_en(rd_en), .rd_addr(rd_addr), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    // Model: per-VOQ descriptor queues, plus the list of words still to be read out.
    typedef struct packed {
        logic [5:0] len;
        logic [9:0] addr;
    } desc_t;

    typedef struct packed {
        logic [9:0] addr;
        logic       sop;
        logic       eop;
        logic [1:0] voq;
    } word_t;

    desc_t mq0[$];
    desc_t mq1[$];
    desc_t mq2[$];
    desc_t mq3[$];
    word_t wq[$];
    logic  m_drop = 1'b0;
    logic  m_gerr = 1'b0;

    int  n_vec = 0;
    int  n_bad = 0;
    bit  chk_en = 1'b0;

    function automatic int qsize(input logic [1:0] v);
        case (v)
            2'd0: return mq0.size();
            2'd1: return mq1.size();
            2'd2: return mq2.size();
            default: return mq3.size();
        endcase
    endfunction

    task automatic qpop(input logic [1:0] v, output desc_t d);
        case (v)
            2'd0: d = mq0.pop_front();
            2'd1: d = mq1.pop_front();
            2'd2: d = mq2.pop_front();
            default: d = mq3.pop_front();
        endcase
    endtask

    task automatic qpush(input logic [1:0] v, input desc_t d);
        case (v)
            2'd0: mq0.push_back(d);
            2'd1: mq1.push_back(d);
            2'd2: mq2.push_back(d);
            default: mq3.push_back(d);
        endcase
    endtask

    // Advance the model by one clock edge using the inputs presented before that edge.
    task automatic model_update();
        bit         busy;
        logic [1:0] cur_voq;
        bit         drop;
        bit         gok;
        bit         gerr;
        desc_t      d;
        word_t      w;
        if (reset) begin
            mq0.delete(); mq1.delete(); mq2.delete(); mq3.delete();
            wq.delete();
            m_drop = 1'b0;
            m_gerr = 1'b0;
            return;
        end
        busy    = (wq.size() != 0);
        cur_voq = busy ? wq[0].voq : 2'd0;
        drop    = enq_valid && ((enq_len == 6'd0) || (qsize(enq_voq) >= DEPTH));
        gok     = !busy && sel_en && (qsize(sel) != 0);
        gerr    = sel_en && (busy ? (sel != cur_voq) : (qsize(sel) == 0));
        if (busy) void'(wq.pop_front());
        if (gok) begin
            qpop(sel, d);
            for (int i = 0; i < int'(d.len); i++) begin
                w.addr = d.addr + 10'(i);
                w.sop  = (i == 0);
                w.eop  = (i == int'(d.len) - 1);
                w.voq  = sel;
                wq.push_back(w);
            end
        end
        if (enq_valid && !drop) qpush(enq_voq, {enq_len, enq_addr});
        m_drop = drop;
        m_gerr = gerr;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] e_empty;
            bit         e_busy;
            e_busy  = (wq.size() != 0);
            e_empty = {qsize(2'd3) == 0, qsize(2'd2) == 0, qsize(2'd1) == 0, qsize(2'd0) == 0};
            chk("enq_drop", 32'(enq_drop), 32'(m_drop));
            chk("grant_err", 32'(grant_err), 32'(m_gerr));
            chk("voq_empty", 32'(voq_empty), 32'(e_empty));
            chk("is_busy", 32'(is_busy), 32'(e_busy));
            chk("rd_en", 32'(rd_en), 32'(e_busy));
            chk("busy_voq_num", 32'(busy_voq_num), e_busy ? 32'(wq[0].voq) : 32'd0);
            chk("tx_sop", 32'(tx_sop), e_busy ? 32'(wq[0].sop) : 32'd0);
            chk("tx_eop", 32'(tx_eop), e_busy ? 32'(wq[0].eop) : 32'd0);
            if (e_busy) chk("rd_addr", 32'(rd_addr), 32'(wq[0].addr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic quiet();
        reset     = 1'b0;
        enq_valid = 1'b0;
        enq_voq   = 2'd0;
        enq_len   = 6'd0;
        enq_addr  = 10'd0;
        sel_en    = 1'b0;
        sel       = 2'd0;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic enq(input logic [1:0] v, input logic [5:0] len, input logic [9:0] addr);
        enq_valid = 1'b1;
        enq_voq   = v;
        enq_len   = len;
        enq_addr  = addr;
        cyc();
        enq_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 80 && wq.size() != 0; k++) cyc();
        cyc();
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc();
        reset = 1'b0;
        at_neg();
        chk("rst voq_empty", 32'(voq_empty), 32'hF);
        chk("rst rd_en", 32'(rd_en), 32'd0);
        chk("rst rd_addr", 32'(rd_addr), 32'd0);
        chk("rst is_busy", 32'(is_busy), 32'd0);

        // Address wrap at the top of the buffer.
        enq(2'd2, 6'd3, 10'h3FE);
        sel_en = 1'b1; sel = 2'd2;
        cyc();
        sel_en = 1'b0;
        at_neg();
        chk("wrap w0 addr", 32'(rd_addr), 32'h3FE);
        chk("wrap w0 sop", 32'(tx_sop), 32'd1);
        chk("wrap empty", 32'(voq_empty), 32'hF);
        cyc(); at_neg();
        chk("wrap w1 addr", 32'(rd_addr), 32'h3FF);
        cyc(); at_neg();
        chk("wrap w2 addr", 32'(rd_addr), 32'h000);
        chk("wrap w2 eop", 32'(tx_eop), 32'd1);
        cyc(); at_neg();
        chk("wrap done rd_en", 32'(rd_en), 32'd0);

        // Full VOQ: plain overflow and overflow with a simultaneous pop.
        for (int i = 0; i < DEPTH; i++) enq(2'd1, 6'd2, 10'(16 * i));
        enq(2'd1, 6'd2, 10'h155);
        at_neg();
        chk("full drop", 32'(enq_drop), 32'd1);
        enq_valid = 1'b1; enq_voq = 2'd1; enq_len = 6'd2; enq_addr = 10'h2AA;
        sel_en = 1'b1; sel = 2'd1;
        cyc();
        quiet();
        at_neg();
        chk("full pop drop", 32'(enq_drop), 32'd1);
        chk("full pop busy", 32'(is_busy), 32'd1);
        drain();

        // Grant to an empty VOQ.
        do_reset();
        sel_en = 1'b1; sel = 2'd0;
        cyc();
        sel_en = 1'b0;
        at_neg();
        chk("empty grant_err", 32'(grant_err), 32'd1);
        chk("empty grant busy", 32'(is_busy), 32'd0);
        chk("empty grant rd_en", 32'(rd_en), 32'd0);
        cyc(); at_neg();
        chk("grant_err pulse", 32'(grant_err), 32'd0);

        // Re-grants during a len-4 packet from VOQ 3.
        enq(2'd3, 6'd4, 10'h100);
        sel_en = 1'b1; sel = 2'd3;
        cyc();
        cyc();
        at_neg();
        chk("regrant ignored", 32'(grant_err), 32'd0);
        chk("regrant addr", 32'(rd_addr), 32'h101);
        sel = 2'd1;
        cyc();
        sel_en = 1'b0;
        at_neg();
        chk("foreign grant_err", 32'(grant_err), 32'd1);
        chk("foreign busy voq", 32'(busy_voq_num), 32'd3);
        cyc(); at_neg();
        chk("len4 eop", 32'(tx_eop), 32'd1);
        chk("len4 last addr", 32'(rd_addr), 32'h103);
        cyc(); at_neg();
        chk("len4 idle", 32'(rd_en), 32'd0);

        // len-1 packet followed by a held grant.
        enq(2'd0, 6'd1, 10'h020);
        enq(2'd0, 6'd2, 10'h040);
        sel_en = 1'b1; sel = 2'd0;
        cyc();
        at_neg();
        chk("len1 sop", 32'(tx_sop), 32'd1);
        chk("len1 eop", 32'(tx_eop), 32'd1);
        chk("len1 addr", 32'(rd_addr), 32'h020);
        cyc();
        at_neg();
        chk("len1 gap", 32'(rd_en), 32'd0);
        cyc();
        sel_en = 1'b0;
        at_neg();
        chk("next pkt sop", 32'(tx_sop), 32'd1);
        chk("next pkt addr", 32'(rd_addr), 32'h040);
        drain();

        // Reset in the second word of a len-5 packet; enqueue in the reset cycle ignored.
        enq(2'd1, 6'd5, 10'h200);
        sel_en = 1'b1; sel = 2'd1;
        cyc();
        sel_en = 1'b0;
        cyc();
        reset = 1'b1;
        enq_valid = 1'b1; enq_voq = 2'd2; enq_len = 6'd3; enq_addr = 10'h010;
        cyc();
        quiet();
        at_neg();
        chk("abort rd_en", 32'(rd_en), 32'd0);
        chk("abort empty", 32'(voq_empty), 32'hF);
        chk("abort busy", 32'(is_busy), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            enq_valid = ($urandom_range(0, 9) < 6);
            enq_voq   = 2'($urandom_range(0, 3));
            enq_len   = ($urandom_range(0, 15) == 0) ? 6'd0 :
                        ($urandom_range(0, 31) == 0) ? 6'd63 : 6'($urandom_range(1, 6));
            enq_addr  = 10'($urandom_range(0, 1023));
            sel_en    = ($urandom_range(0, 9) < 4);
            sel       = 2'($urandom_range(0, 3));
            cyc();
        end
        quiet();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
